// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of the 2-slot VLIW core.
//
// Fetches one 32-bit bundle per cycle ([15:0] ALU slot, [31:16] MEM slot),
// drives the IF/ID (p1) pipeline register, applies EX-stage redirects and
// absorbs a response that lands while ID is stalled in a one-entry skid buffer.
//
// Optional feature macro: IF_PERF_COUNTERS_EN (adds fetch_count/stall_count).
//
// Ports
//   clk                   in   clock, rising edge
//   reset                 in   asynchronous, active-low reset
//   p1_pipeline_regWrite  in   1 = ID consumes p1 this cycle, 0 = p1 holds
//   redirect              in   taken branch/jump from EX
//   redirect_target       in   new PC (bits [1:0] forced to 0)
//   imem_req              out  fetch request
//   imem_addr             out  bundle address, stable until imem_ready
//   imem_ready            in   response valid this cycle
//   imem_rdata            in   bundle data
//   p1_aluInstr           out  ALU-slot instruction
//   p1_memInstr           out  MEM-slot instruction
//   p1_pc                 out  address of the bundle in p1
//   p1_pcPlus4            out  p1_pc + 4
//   p1_valid              out  p1 holds a real bundle
//   fetch_count           out  [IF_PERF_COUNTERS_EN] bundles delivered to ID
//   stall_count           out  [IF_PERF_COUNTERS_EN] cycles p1 valid but stalled
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_pipeline_regWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [15:0] p1_aluInstr,
  output logic [15:0] p1_memInstr,
  output logic [31:0] p1_pc,
  output logic [31:0] p1_pcPlus4,
  output logic        p1_valid
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] pcTarget;
  logic [31:0] addrReg;
  logic        reqReg;
  logic        bufValid;
  logic [31:0] bufData;
  logic [31:0] bufPc;
  logic        p1ValidReg;
  logic [31:0] p1BundleReg;
  logic [31:0] p1PcReg;
  logic [31:0] p1PcPlus4Reg;
  logic        fetchHit;
  logic        unusedTargetBits;

  // The low target bits are architecturally ignored.
  assign unusedTargetBits = ^redirect_target[1:0];
  assign pcTarget         = {redirect_target[31:2], 2'b00};

  // Only a response to a live (non-stale) request in FETCH is a real bundle.
  assign fetchHit = reqReg && imem_ready && (state == FETCH);

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    if (redirect) begin
      pcNext = pcTarget;
      // A request still waiting for its response must be drained first.
      stateNext = (reqReg && !imem_ready) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (fetchHit) begin
            pcNext = pc + 32'd4;
            if (!p1_pipeline_regWrite) stateNext = FULL;
          end
        end
        FULL:    if (p1_pipeline_regWrite) stateNext = FETCH;
        DRAIN:   if (imem_ready) stateNext = FETCH;
        default: stateNext = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      addrReg      <= RESET_PC;
      reqReg       <= 1'b0;
      bufValid     <= 1'b0;
      bufData      <= 32'd0;
      bufPc        <= 32'd0;
      p1ValidReg   <= 1'b0;
      p1BundleReg  <= {NOP_INSTR, NOP_INSTR};
      p1PcReg      <= 32'd0;
      p1PcPlus4Reg <= 32'd0;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      reqReg <= (stateNext != FULL);
      // While draining, the bus must keep the stale address until its response.
      if (stateNext != DRAIN) addrReg <= pcNext;

      // Skid buffer: filled by a response that arrives while ID stalls.
      if (redirect) begin
        bufValid <= 1'b0;
      end else if (fetchHit && !p1_pipeline_regWrite) begin
        bufValid <= 1'b1;
        bufData  <= imem_rdata;
        bufPc    <= pc;
      end else if ((state == FULL) && p1_pipeline_regWrite) begin
        bufValid <= 1'b0;
      end

      // p1 register: redirect flushes; otherwise buffer > fresh data > bubble.
      if (redirect) begin
        p1ValidReg   <= 1'b0;
        p1BundleReg  <= {NOP_INSTR, NOP_INSTR};
        p1PcReg      <= 32'd0;
        p1PcPlus4Reg <= 32'd4;
      end else if (p1_pipeline_regWrite) begin
        if (bufValid) begin
          p1ValidReg   <= 1'b1;
          p1BundleReg  <= bufData;
          p1PcReg      <= bufPc;
          p1PcPlus4Reg <= bufPc + 32'd4;
        end else if (fetchHit) begin
          p1ValidReg   <= 1'b1;
          p1BundleReg  <= imem_rdata;
          p1PcReg      <= pc;
          p1PcPlus4Reg <= pc + 32'd4;
        end else begin
          p1ValidReg   <= 1'b0;
          p1BundleReg  <= {NOP_INSTR, NOP_INSTR};
          p1PcReg      <= 32'd0;
          p1PcPlus4Reg <= 32'd4;
        end
      end
    end
  end

  assign imem_req    = reqReg;
  assign imem_addr   = addrReg;
  assign p1_valid    = p1ValidReg;
  assign p1_aluInstr = p1BundleReg[15:0];
  assign p1_memInstr = p1BundleReg[31:16];
  assign p1_pc       = p1PcReg;
  assign p1_pcPlus4  = p1PcPlus4Reg;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetchCountReg;
  logic [31:0] stallCountReg;

  // Counts reflect what ID does with the current p1 content this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchCountReg <= 32'd0;
      stallCountReg <= 32'd0;
    end else begin
      if (p1ValidReg && p1_pipeline_regWrite)  fetchCountReg <= fetchCountReg + 32'd1;
      if (p1ValidReg && !p1_pipeline_regWrite) stallCountReg <= stallCountReg + 32'd1;
    end
  end

  assign fetch_count = fetchCountReg;
  assign stall_count = stallCountReg;
`endif

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [15:0] p1_aluInstr;
  logic [15:0] p1_memInstr;
  logic [31:0] p1_pc;
  logic [31:0] p1_pcPlus4;
  logic        p1_valid;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .p1_pipeline_regWrite (regWrite),
    .redirect             (redirect),
    .redirect_target      (target),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ready           (imem_ready),
    .imem_rdata           (imem_rdata),
    .p1_aluInstr          (p1_aluInstr),
    .p1_memInstr          (p1_memInstr),
    .p1_pc                (p1_pc),
    .p1_pcPlus4           (p1_pcPlus4),
    .p1_valid             (p1_valid)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetch_count          (fetch_count),
    .stall_count          (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } bundle_t;

  bundle_t     skidQ[$];
  bundle_t     mP1;
  bit          mP1Valid;
  bit          mP1Fresh;
  bit          mStarted;
  bit          mStale;
  logic [31:0] mStaleAddr;
  logic [31:0] mPc;
  logic [31:0] mFetchCnt;
  logic [31:0] mStallCnt;

  // memory model
  bit memBusy;
  int memWait;
  int fixLat = 0;
  int maxLat = 3;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[17:2], a[15:0] ^ 16'hA5C3};
  endfunction

  function automatic bit modelReq();
    return mStarted && (skidQ.size() == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    skidQ.delete();
    mP1.pc = 32'd0; mP1.data = 32'd0;
    mP1Valid = 0; mP1Fresh = 1; mStarted = 0; mStale = 0;
    mStaleAddr = 32'd0; mPc = 32'd0; mFetchCnt = 32'd0; mStallCnt = 32'd0;
    memBusy = 0; memWait = 0;
  endtask

  task automatic checkOutputs();
    bit          req;
    logic [31:0] expAddr;
    req     = modelReq();
    expAddr = mStale ? mStaleAddr : mPc;
    chk("imem_req", 32'(imem_req), 32'(req));
    if (req) chk("imem_addr", imem_addr, expAddr);
    chk("p1_valid", 32'(p1_valid), 32'(mP1Valid));
    chk("p1_aluInstr", 32'(p1_aluInstr), mP1Valid ? 32'(mP1.data[15:0]) : 32'd0);
    chk("p1_memInstr", 32'(p1_memInstr), mP1Valid ? 32'(mP1.data[31:16]) : 32'd0);
    if (mP1Valid) begin
      chk("p1_pc", p1_pc, mP1.pc);
      chk("p1_pcPlus4", p1_pcPlus4, mP1.pc + 32'd4);
    end else begin
      chk("p1_pcPlus4_bubble", p1_pcPlus4, mP1Fresh ? 32'd0 : p1_pc + 32'd4);
    end
`ifdef IF_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, mFetchCnt);
    chk("stall_count", stall_count, mStallCnt);
`endif
  endtask

  // Drive inputs for the coming edge; the bench plays instruction memory.
  task automatic drive(input bit rw, input bit rd, input logic [31:0] tgt);
    regWrite = rw;
    redirect = rd;
    target   = tgt;
    if (imem_req && !memBusy) begin
      memBusy = 1;
      memWait = (fixLat >= 0) ? fixLat : int'($urandom_range(maxLat, 0));
    end
    imem_ready = memBusy && (memWait == 0) && imem_req;
    imem_rdata = imem_ready ? memWord(imem_addr) : $urandom;
  endtask

  task automatic modelStep();
    bundle_t inc;
    bit      hasInc;
    bit      req;
    bit      got;
    hasInc = 0;
    req    = modelReq();
    got    = req && imem_ready;
    if (mP1Valid && regWrite)  mFetchCnt++;
    if (mP1Valid && !regWrite) mStallCnt++;
    if (redirect) begin
      if (req && !imem_ready) begin
        if (!mStale) mStaleAddr = mPc;
        mStale = 1;
      end else begin
        mStale = 0;
      end
      mPc = {target[31:2], 2'b00};
      skidQ.delete();
      mP1Valid = 0;
      mP1Fresh = 0;
    end else begin
      if (got) begin
        if (mStale) begin
          mStale = 0;
        end else begin
          inc.pc = mPc; inc.data = imem_rdata; hasInc = 1;
          mPc = mPc + 32'd4;
        end
      end
      if (regWrite) begin
        mP1Fresh = 0;
        if (skidQ.size() > 0) begin
          mP1 = skidQ.pop_front(); mP1Valid = 1;
        end else if (hasInc) begin
          mP1 = inc; mP1Valid = 1;
        end else begin
          mP1Valid = 0;
        end
      end else if (hasInc) begin
        skidQ.push_back(inc);
      end
    end
    mStarted = 1;
    // memory side
    if (imem_ready) memBusy = 0;
    else if (memBusy && memWait > 0) memWait--;
  endtask

  // One cycle: compare at negedge, drive, advance model at posedge.
  task automatic runCycle(input bit rw, input bit rd, input logic [31:0] tgt);
    checkOutputs();
    drive(rw, rd, tgt);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic waitStale();
    for (int i = 0; i < 12; i++) begin
      if (memBusy && memWait >= 1) break;
      runCycle(1, 0, 32'd0);
    end
    chk("outstanding_req_reached", 32'(memBusy && memWait >= 1), 32'd1);
  endtask

  initial begin
    bit          found;
    logic [31:0] stallBefore;
    reset = 1'b0; regWrite = 1'b1; redirect = 1'b0; target = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    stallBefore = 32'd0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset release, zero-wait memory.
    fixLat = 0;
    runCycle(1, 0, 32'd0);
    runCycle(1, 0, 32'd0);
    chk("lit_addr_4", imem_addr, 32'd4);
    chk("lit_p1_pc_0", p1_pc, 32'd0);
    chk("lit_p1_valid", 32'(p1_valid), 32'd1);
    runCycle(1, 0, 32'd0);
    chk("lit_addr_8", imem_addr, 32'd8);
    chk("lit_p1_pc_4", p1_pc, 32'd4);
    repeat (3) runCycle(1, 0, 32'd0);

    // Four stall cycles with zero-wait memory.
`ifdef IF_PERF_COUNTERS_EN
    stallBefore = stall_count;
`endif
    runCycle(0, 0, 32'd0);
    runCycle(0, 0, 32'd0);
    chk("lit_req_in_full", 32'(imem_req), 32'd0);
    runCycle(0, 0, 32'd0);
    runCycle(0, 0, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
    chk("lit_stall_delta", stall_count - stallBefore, 32'd4);
`endif
    repeat (6) runCycle(1, 0, 32'd0);

    // Redirect with a request outstanding.
    fixLat = 3;
    waitStale();
    runCycle(1, 1, 32'h0000_0103);
    chk("lit_bubble_after_redirect", 32'(p1_valid), 32'd0);
    chk("lit_drain_req", 32'(imem_req), 32'd1);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'h0000_0100) begin found = 1; break; end
      runCycle(1, 0, 32'd0);
    end
    chk("lit_redirect_addr_100", 32'(found), 32'd1);

    // PC wrap.
    fixLat = 0;
    runCycle(1, 1, 32'hFFFF_FFFE);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'hFFFF_FFFC) begin found = 1; break; end
      runCycle(1, 0, 32'd0);
    end
    chk("lit_addr_fffffffc", 32'(found), 32'd1);
    runCycle(1, 0, 32'd0);
    chk("lit_wrap_addr_0", imem_addr, 32'd0);
    chk("lit_wrap_p1_pc", p1_pc, 32'hFFFF_FFFC);

    // Reset asserted while draining.
    fixLat = 3;
    waitStale();
    runCycle(1, 1, 32'h0000_0040);
    chk("lit_drain_before_reset", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("lit_rst_req", 32'(imem_req), 32'd0);
    chk("lit_rst_valid", 32'(p1_valid), 32'd0);
    chk("lit_rst_alu", 32'(p1_aluInstr), 32'd0);
    chk("lit_rst_mem", 32'(p1_memInstr), 32'd0);
    chk("lit_rst_pc", p1_pc, 32'd0);
    chk("lit_rst_pcPlus4", p1_pcPlus4, 32'd0);
    chk("lit_rst_addr", imem_addr, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
    chk("lit_rst_fetch_count", fetch_count, 32'd0);
    chk("lit_rst_stall_count", stall_count, 32'd0);
`endif
    modelReset();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic.
    fixLat = -1;
    maxLat = 3;
    for (int i = 0; i < 1500; i++) begin
      runCycle($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, $urandom);
    end
    checkOutputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
